uart_cfg_seq: RTL and testbench

//  Wishbone configuration sequencer and arbiter in front of the UART register port.
//  On start it programs the UART in order: divisor latch, line control, FIFO control, interrupt enable.

---
 rtl/uart_cfg_seq.sv | 216 +++++++++++++++++++++
 tb/tb_uart_cfg_seq.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cfg_seq.sv
// ============================================================================
// uart_cfg_seq
// ----------------------------------------------------------------------------
// Wishbone configuration sequencer and arbiter in front of a 16550-style UART
// register port. A start request (start_i pulse, or automatically once after
// reset when AUTO_START=1) programs the UART in six writes:
//   S0 LCR with DLAB=1, S1 DLL, S2 DLM, S3 LCR with DLAB=0, S4 FCR, S5 IER.
// Each write is WRITE (strobe out) -> ACKWAIT (hold until u_ack_i) -> GAP
// (one idle bus cycle), so a zero-wait slave costs 3 cycles per step.
// When the sequencer is idle the host Wishbone port is passed straight
// through to the UART port.
//
// Ports
//   wb_clk_i, wb_rst_i        clock, asynchronous active-high reset
//   start_i                   pulse: begin configuration sequence
//   divisor_i/lcr_i/fcr_i/ier_i  configuration values, latched at start
//   busy_o                    sequence pending or running
//   done_o                    one-cycle pulse on successful completion
//   err_o                     sticky: last sequence aborted on ack timeout
//   h_*                       host Wishbone slave port
//   u_*                       UART Wishbone master port
// ============================================================================
module uart_cfg_seq #(
    parameter int ADDR_WIDTH  = 3,
    parameter int ACK_TIMEOUT = 15,
    parameter int AUTO_START  = 0
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  start_i,
    input  logic [15:0]           divisor_i,
    input  logic [7:0]            lcr_i,
    input  logic [7:0]            fcr_i,
    input  logic [7:0]            ier_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    input  logic [ADDR_WIDTH-1:0] h_adr_i,
    input  logic [7:0]            h_dat_i,
    output logic [7:0]            h_dat_o,
    input  logic                  h_we_i,
    input  logic                  h_stb_i,
    input  logic                  h_cyc_i,
    output logic                  h_ack_o,
    output logic [ADDR_WIDTH-1:0] u_adr_o,
    output logic [7:0]            u_dat_o,
    input  logic [7:0]            u_dat_i,
    output logic                  u_we_o,
    output logic                  u_stb_o,
    output logic                  u_cyc_o,
    input  logic                  u_ack_i
);

    // Counter only has to hold 0 .. ACK_TIMEOUT-1.
    localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [2:0]       LAST_STEP = 3'd5;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_HOST,
        WRITE,
        ACKWAIT,
        GAP
    } state_t;

    state_t           state_reg, state_next;
    logic [2:0]       step_reg, step_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             err_reg, err_next;
    logic             auto_reg, auto_next;
    logic [15:0]      div_reg;
    logic [6:0]       lcr_reg;
    logic [7:0]       fcr_reg;
    logic [7:0]       ier_reg;
    logic             load_cfg;
    logic             pass_thru;
    logic             seq_drive;
    logic             seq_done;
    logic [ADDR_WIDTH-1:0] seq_adr;
    logic [7:0]       seq_dat;
    logic             pass_live;

    // DLAB is dictated by the step table, so the caller's bit 7 is dropped.
    logic unused_lcr_dlab;
    assign unused_lcr_dlab = lcr_i[7];

    // ------------------------------------------------------------------
    // State and configuration registers
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_reg <= IDLE;
            step_reg  <= 3'd0;
            cnt_reg   <= '0;
            err_reg   <= 1'b0;
            auto_reg  <= (AUTO_START != 0);
            div_reg   <= 16'd0;
            lcr_reg   <= 7'd0;
            fcr_reg   <= 8'd0;
            ier_reg   <= 8'd0;
        end else begin
            state_reg <= state_next;
            step_reg  <= step_next;
            cnt_reg   <= cnt_next;
            err_reg   <= err_next;
            auto_reg  <= auto_next;
            if (load_cfg) begin
                div_reg <= divisor_i;
                lcr_reg <= lcr_i[6:0];
                fcr_reg <= fcr_i;
                ier_reg <= ier_i;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        step_next  = step_reg;
        cnt_next   = cnt_reg;
        err_next   = err_reg;
        auto_next  = auto_reg;
        load_cfg   = 1'b0;
        pass_thru  = 1'b0;
        seq_drive  = 1'b0;
        seq_done   = 1'b0;

        case (state_reg)
            IDLE: begin
                pass_thru = 1'b1;
                // A pending auto start and an explicit start merge into one run.
                if (start_i || auto_reg) begin
                    load_cfg   = 1'b1;
                    err_next   = 1'b0;
                    auto_next  = 1'b0;
                    step_next  = 3'd0;
                    state_next = h_cyc_i ? WAIT_HOST : WRITE;
                end
            end
            WAIT_HOST: begin
                // Let the host finish its bus cycle before taking the bus.
                pass_thru = 1'b1;
                if (!h_cyc_i) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                seq_drive  = 1'b1;
                cnt_next   = '0;
                state_next = ACKWAIT;
            end
            ACKWAIT: begin
                seq_drive = 1'b1;
                if (u_ack_i) begin
                    state_next = GAP;
                end else if (cnt_reg == CNT_LAST) begin
                    err_next   = 1'b1;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            GAP: begin
                if (step_reg == LAST_STEP) begin
                    seq_done   = 1'b1;
                    state_next = IDLE;
                end else begin
                    step_next  = step_reg + 1'b1;
                    state_next = WRITE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Step table: register address and value written at each step
    // ------------------------------------------------------------------
    always_comb begin
        seq_adr = '0;
        seq_dat = 8'd0;
        case (step_reg)
            3'd0: begin seq_adr = ADDR_WIDTH'(3); seq_dat = {1'b1, lcr_reg}; end
            3'd1: begin seq_adr = ADDR_WIDTH'(0); seq_dat = div_reg[7:0];    end
            3'd2: begin seq_adr = ADDR_WIDTH'(1); seq_dat = div_reg[15:8];   end
            3'd3: begin seq_adr = ADDR_WIDTH'(3); seq_dat = {1'b0, lcr_reg}; end
            3'd4: begin seq_adr = ADDR_WIDTH'(2); seq_dat = fcr_reg;         end
            3'd5: begin seq_adr = ADDR_WIDTH'(1); seq_dat = ier_reg;         end
            default: begin seq_adr = '0; seq_dat = 8'd0; end
        endcase
    end

    // ------------------------------------------------------------------
    // Bus mux. The pass-through path is combinational from the host, so it
    // is gated by reset to keep the UART port quiet while reset is held.
    // ------------------------------------------------------------------
    assign pass_live = pass_thru & ~wb_rst_i;

    assign u_adr_o = pass_live ? h_adr_i : seq_adr;
    assign u_dat_o = pass_live ? h_dat_i : seq_dat;
    assign u_we_o  = pass_live ? h_we_i  : seq_drive;
    assign u_stb_o = pass_live ? h_stb_i : seq_drive;
    assign u_cyc_o = pass_live ? h_cyc_i : seq_drive;
    assign h_ack_o = pass_live & u_ack_i;
    assign h_dat_o = u_dat_i;

    assign busy_o  = (state_reg != IDLE);
    assign done_o  = seq_done;
    assign err_o   = err_reg;

endmodule

// File: tb/tb_uart_cfg_seq.sv
// ============================================================================
// tb_uart_cfg_seq
// ----------------------------------------------------------------------------
// Self-checking bench for uart_cfg_seq (AUTO_START=1, ACK_TIMEOUT=15).
// A small UART slave model answers one cycle after seeing a strobe; a
// monitor logs every acknowledged UART write. Expected write lists are built
// from the register programming order with plain arithmetic.
// ============================================================================
module tb_uart_cfg_seq;

    localparam int AW = 3;
    localparam int TO = 15;

    logic          clk;
    logic          rst;
    logic          start_i;
    logic [15:0]   divisor_i;
    logic [7:0]    lcr_i, fcr_i, ier_i;
    logic          busy_o, done_o, err_o;
    logic [AW-1:0] h_adr;
    logic [7:0]    h_dat_w, h_dat_r;
    logic          h_we, h_stb, h_cyc, h_ack;
    logic [AW-1:0] u_adr;
    logic [7:0]    u_dat_w, u_dat_r;
    logic          u_we, u_stb, u_cyc, u_ack;

    int n_chk = 0;
    int n_err = 0;
    int obs_q[$];
    int exp_q[$];
    int done_cnt = 0;
    int done_base = 0;
    int run_len = 0;
    int last_run = 0;
    int withhold_idx = -1;
    int cfg_div, cfg_lcr, cfg_fcr, cfg_ier;
    int cyc;
    logic [7:0] rd_data;
    logic       ack_q;

    uart_cfg_seq #(
        .ADDR_WIDTH  (AW),
        .ACK_TIMEOUT (TO),
        .AUTO_START  (1)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .start_i   (start_i),
        .divisor_i (divisor_i),
        .lcr_i     (lcr_i),
        .fcr_i     (fcr_i),
        .ier_i     (ier_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .err_o     (err_o),
        .h_adr_i   (h_adr),
        .h_dat_i   (h_dat_w),
        .h_dat_o   (h_dat_r),
        .h_we_i    (h_we),
        .h_stb_i   (h_stb),
        .h_cyc_i   (h_cyc),
        .h_ack_o   (h_ack),
        .u_adr_o   (u_adr),
        .u_dat_o   (u_dat_w),
        .u_dat_i   (u_dat_r),
        .u_we_o    (u_we),
        .u_stb_o   (u_stb),
        .u_cyc_o   (u_cyc),
        .u_ack_i   (u_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // UART slave: acks one cycle after a strobe; can withhold the ack of
    // the write with a given index in the current sequence.
    always @(posedge clk or posedge rst) begin
        if (rst) ack_q <= 1'b0;
        else     ack_q <= u_cyc && u_stb && !ack_q &&
                          !(u_we && (obs_q.size() == withhold_idx));
    end
    assign u_ack   = ack_q;
    assign u_dat_r = rd_data;

    // Monitor: acknowledged writes, done pulses, length of write strobes.
    always @(negedge clk) begin
        if (u_cyc === 1'b1 && u_stb === 1'b1 && u_we === 1'b1 && u_ack === 1'b1) begin
            obs_q.push_back(int'(u_adr) * 256 + int'(u_dat_w));
            $display("wr adr=%0d dat=0x%02h t=%0t", u_adr, u_dat_w, $time);
        end
        if (done_o === 1'b1) done_cnt++;
        if (u_stb === 1'b1 && u_we === 1'b1) run_len++;
        else if (run_len != 0) begin
            last_run = run_len;
            run_len  = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Choose a configuration, drive it and build the expected write list.
    task automatic new_cfg(input bit fixed);
        if (fixed) begin
            cfg_div = 'h0145; cfg_lcr = 'h03; cfg_fcr = 'hC7; cfg_ier = 'h01;
        end else begin
            cfg_div = int'($urandom_range(0, 65535));
            cfg_lcr = int'($urandom_range(0, 255));
            cfg_fcr = int'($urandom_range(0, 255));
            cfg_ier = int'($urandom_range(0, 255));
        end
        divisor_i = cfg_div[15:0];
        lcr_i     = cfg_lcr[7:0];
        fcr_i     = cfg_fcr[7:0];
        ier_i     = cfg_ier[7:0];
        exp_q.delete();
        exp_q.push_back(3 * 256 + 128 + cfg_lcr % 128);
        exp_q.push_back(0 * 256 + cfg_div % 256);
        exp_q.push_back(1 * 256 + cfg_div / 256);
        exp_q.push_back(3 * 256 + cfg_lcr % 128);
        exp_q.push_back(2 * 256 + cfg_fcr);
        exp_q.push_back(1 * 256 + cfg_ier);
    endtask

    task automatic seq_begin();
        obs_q.delete();
        done_base = done_cnt;
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    // Waits for done_o; with chk_lat, the first cycle must already strobe
    // and done must land exactly 18 cycles after the start cycle.
    task automatic wait_done(input string tag, input int budget, input bit chk_lat);
        cyc = 0;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            if (chk_lat && k == 1) check({tag, " first stb"}, u_stb, 1'b1);
            if (done_o === 1'b1) begin
                cyc = k;
                break;
            end
        end
        check({tag, " done"}, done_o, 1'b1);
        if (chk_lat) check({tag, " latency"}, cyc, 18);
    endtask

    task automatic end_seq(input string tag);
        @(negedge clk);
        check({tag, " done width"}, done_o, 1'b0);
        check({tag, " busy end"}, busy_o, 1'b0);
        check({tag, " err end"}, err_o, 1'b0);
        check({tag, " done count"}, done_cnt - done_base, 1);
    endtask

    task automatic cmp_writes(input string tag, input int n);
        check({tag, " nwr"}, obs_q.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < obs_q.size()) check($sformatf("%s wr%0d", tag, i), obs_q[i], exp_q[i]);
        end
    endtask

    initial begin
        rst = 1'b1; start_i = 1'b0;
        h_adr = '0; h_dat_w = 8'd0; h_we = 1'b0; h_stb = 1'b0; h_cyc = 1'b0;
        rd_data = 8'd0;
        new_cfg(1);
        repeat (3) @(posedge clk);

        // Reset state
        @(negedge clk);
        check("rst busy", busy_o, 1'b0);
        check("rst done", done_o, 1'b0);
        check("rst err", err_o, 1'b0);
        check("rst stb", u_stb, 1'b0);
        check("rst cyc", u_cyc, 1'b0);
        check("rst we", u_we, 1'b0);
        check("rst hack", h_ack, 1'b0);

        // Auto start plus coincident start_i: one sequence, reference values
        @(posedge clk); #1;
        rst = 1'b0; start_i = 1'b1;
        seq_begin();
        tick();
        start_i = 1'b0;
        wait_done("t1", 40, 1'b1);
        end_seq("t1");
        cmp_writes("t1", 6);

        // Random configurations, software start
        for (int r = 0; r < 4; r++) begin
            tick();
            new_cfg(0);
            seq_begin();
            pulse_start();
            wait_done($sformatf("rnd%0d", r), 40, 1'b1);
            end_seq($sformatf("rnd%0d", r));
            cmp_writes($sformatf("rnd%0d", r), 6);
        end

        // Host read in IDLE
        tick();
        rd_data = 8'($urandom_range(0, 255));
        h_adr = 3'd2; h_we = 1'b0; h_cyc = 1'b1; h_stb = 1'b1;
        @(negedge clk);
        check("t2 stb", u_stb, 1'b1);
        check("t2 we", u_we, 1'b0);
        check("t2 adr", u_adr, 3'd2);
        check("t2 rdat", h_dat_r, rd_data);
        check("t2 hack0", h_ack, 1'b0);
        @(negedge clk);
        check("t2 hack1", h_ack, 1'b1);
        tick();
        h_cyc = 1'b0; h_stb = 1'b0;

        // Start while host owns the bus
        tick();
        new_cfg(0);
        h_adr = 3'd1; h_we = 1'b0; h_cyc = 1'b1; h_stb = 1'b1;
        seq_begin();
        pulse_start();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("t3 busy", busy_o, 1'b1);
            check("t3 no seq we", u_we, 1'b0);
        end
        tick();
        h_cyc = 1'b0; h_stb = 1'b0;
        @(negedge clk);
        check("t3 stb idle", u_stb, 1'b0);
        @(negedge clk);
        check("t3 s0 stb", u_stb, 1'b1);
        check("t3 s0 adr", u_adr, 3'd3);
        check("t3 s0 dat", u_dat_w, exp_q[0] % 256);
        wait_done("t3", 40, 1'b0);
        end_seq("t3");
        cmp_writes("t3", 6);

        // Host write during a sequence; restart attempt and input changes ignored
        tick();
        new_cfg(0);
        seq_begin();
        pulse_start();
        repeat (3) tick();
        h_adr = 3'd7; h_dat_w = 8'($urandom_range(0, 255));
        h_we = 1'b1; h_cyc = 1'b1; h_stb = 1'b1;
        divisor_i = 16'($urandom_range(0, 65535));
        lcr_i = ~lcr_i; fcr_i = ~fcr_i; ier_i = ~ier_i;
        pulse_start();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("t4 hack held", h_ack, 1'b0);
        end
        wait_done("t4", 40, 1'b0);
        end_seq("t4");
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (h_ack === 1'b1) break;
        end
        check("t4 hack after", h_ack, 1'b1);
        exp_q.push_back(7 * 256 + int'(h_dat_w));
        tick();
        h_cyc = 1'b0; h_stb = 1'b0; h_we = 1'b0;
        cmp_writes("t4", 7);

        // Ack withheld on S2 -> timeout abort
        tick();
        new_cfg(0);
        seq_begin();
        withhold_idx = 2;
        pulse_start();
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (busy_o === 1'b0) break;
        end
        check("t5 busy", busy_o, 1'b0);
        tick();
        check("t5 err", err_o, 1'b1);
        check("t5 cyc", u_cyc, 1'b0);
        check("t5 no done", done_cnt - done_base, 0);
        check("t5 stb len", last_run, TO + 1);
        cmp_writes("t5", 2);
        withhold_idx = -1;
        new_cfg(0);
        seq_begin();
        pulse_start();
        @(negedge clk);
        check("t5 err clr", err_o, 1'b0);
        check("t5 busy2", busy_o, 1'b1);
        wait_done("t5b", 40, 1'b0);
        end_seq("t5b");
        cmp_writes("t5b", 6);

        // Reset in ACKWAIT of S3, then auto restart
        tick();
        new_cfg(0);
        seq_begin();
        pulse_start();
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (obs_q.size() == 3 && u_stb === 1'b1 && u_we === 1'b1) break;
        end
        check("t6 at s3", u_adr, 3'd3);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("t6 stb", u_stb, 1'b0);
        check("t6 cyc", u_cyc, 1'b0);
        check("t6 we", u_we, 1'b0);
        check("t6 busy", busy_o, 1'b0);
        check("t6 done", done_o, 1'b0);
        check("t6 err", err_o, 1'b0);
        check("t6 no done", done_cnt - done_base, 0);
        repeat (2) @(posedge clk);
        #1;
        new_cfg(0);
        seq_begin();
        rst = 1'b0;
        tick();
        wait_done("t6", 40, 1'b1);
        end_seq("t6");
        cmp_writes("t6", 6);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
